// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer, one bit per cycle

module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_load_regfile
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mag_a_q, mag_a_d;
  logic [XLEN-1:0]     mag_b_q, mag_b_d;
  logic [XLEN-1:0]     a_raw_q, a_raw_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div_zero_q, div_zero_d;
  logic                div_ovf_q, div_ovf_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  // Accept-time operand decode: signedness per op, signs and magnitudes
  logic                in_signed_a;
  logic                in_signed_b;
  logic                in_sign_a;
  logic                in_sign_b;
  logic [XLEN-1:0]     in_mag_a;
  logic [XLEN-1:0]     in_mag_b;
  logic                in_div_zero;
  logic                in_div_ovf;

  assign in_signed_a = (i_op != OP_MULHU) && (i_op != OP_DIVU) && (i_op != OP_REMU);
  assign in_signed_b = in_signed_a && (i_op != OP_MULHSU);
  assign in_sign_a   = in_signed_a & i_A[XLEN-1];
  assign in_sign_b   = in_signed_b & i_B[XLEN-1];
  assign in_mag_a    = in_sign_a ? -i_A : i_A;
  assign in_mag_b    = in_sign_b ? -i_B : i_B;
  assign in_div_zero = (i_B == ZERO);
  assign in_div_ovf  = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                       (i_A == MIN_NEG) && (i_B == ALL_ONES);

  // One shift-add multiply step: add multiplicand on the low bit, then shift right
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_step;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, mag_a_q} : {(XLEN+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring divide step: shift remainder:quotient left, subtract if it fits
  logic [XLEN:0]       rem_sh;
  logic [XLEN-1:0]     rem_sub;
  logic                rem_ge;
  logic [2*XLEN-1:0]   div_step;

  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign rem_ge   = (rem_sh >= {1'b0, mag_b_q});
  assign rem_sub  = rem_sh[XLEN-1:0] - mag_b_q;
  assign div_step = rem_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                           : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  // Sign fix-up and result selection, including the divide special cases
  logic [2*XLEN-1:0]   fix_prod;
  logic [XLEN-1:0]     fix_quo;
  logic [XLEN-1:0]     fix_rem;
  logic [XLEN-1:0]     fix_result;

  always_comb begin
    fix_prod   = neg_res_q ? -acc_q : acc_q;
    fix_quo    = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    fix_rem    = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_result = ZERO;
    case (op_q)
      OP_MUL:                       fix_result = fix_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = fix_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero_q)     fix_result = ALL_ONES;
        else if (div_ovf_q) fix_result = MIN_NEG;
        else                fix_result = fix_quo;
      end
      OP_REM, OP_REMU: begin
        if (div_zero_q)     fix_result = a_raw_q;
        else if (div_ovf_q) fix_result = ZERO;
        else                fix_result = fix_rem;
      end
      default:              fix_result = ZERO;
    endcase
  end

  // Sequencer next-state: accept in IDLE, XLEN iterations in CALC, finish in FIX
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    a_raw_d    = a_raw_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    div_ovf_d  = div_ovf_q;
    result_d   = result_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_CALC;
          op_d       = i_op;
          cnt_d      = '0;
          mag_a_d    = in_mag_a;
          mag_b_d    = in_mag_b;
          a_raw_d    = i_A;
          neg_res_d  = in_sign_a ^ in_sign_b;
          neg_rem_d  = in_sign_a;
          div_zero_d = in_div_zero;
          div_ovf_d  = in_div_ovf;
          // Divide seeds the dividend into the quotient half, multiply seeds the multiplier
          acc_d      = i_op[2] ? {ZERO, in_mag_a} : {ZERO, in_mag_b};
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_result;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_MUL;
      cnt_q      <= '0;
      acc_q      <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      a_raw_q    <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      a_raw_q    <= a_raw_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = done_q;
  assign o_load_regfile = done_q;
  assign o_result       = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq with a behavioural RV32M model

module tb_muldiv_seq;

  localparam int XLEN = 32;
  localparam int LAT  = 33;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic        o_load_regfile;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_op           (i_op),
    .i_A            (i_A),
    .i_B            (i_B),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_result       (o_result),
    .o_load_regfile (o_load_regfile)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_done = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_result = 32'h0;

  logic [2:0]  d_op  [0:11] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM,
                                OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
  logic [31:0] d_a   [0:11] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b   [0:11] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_exp [0:11] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  // RV32M semantics from plain 64-bit integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    r  = 32'h0;
    case (op)
      OP_MUL:    begin p = 64'(sa * sb); r = p[31:0];  end
      OP_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * ub); r = p[63:32]; end
      OP_MULHU:  begin p = 64'(ua * ub); r = p[63:32]; end
      OP_DIV: begin
        if (b == 32'h0)                                  r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else begin p = 64'(sa / sb); r = p[31:0]; end
      end
      OP_DIVU:   r = (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      OP_REM: begin
        if (b == 32'h0)                                  r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else begin p = 64'(sa % sb); r = p[31:0]; end
      end
      default:   r = (b == 32'h0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(9))
      0:       v = 32'h0;
      1:       v = 32'hFFFFFFFF;
      2:       v = 32'h80000000;
      3:       v = 32'($urandom_range(15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one start request for a cycle; it is expected to be taken only when idle
  task automatic try_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
    i_op    = op;
    i_A     = a;
    i_B     = b;
    i_start = 1'b1;
    if (!o_busy && !i_reset) begin
      last_done = cyc + 1 + LAT;
      sb_q.push_back('{res: exp, done_cyc: last_done});
    end
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_op    = 3'($urandom);
    i_A     = $urandom;
    i_B     = $urandom;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL completion_timeout at cycle %0d: %0d results outstanding, expected 0",
               cyc, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset(input bit with_start);
    i_reset = 1'b1;
    i_start = with_start;
    i_op    = OP_MUL;
    i_A     = 32'd9;
    i_B     = 32'd9;
    @(posedge clk);
    #1;
    i_reset    = 1'b0;
    i_start    = 1'b0;
    sb_q.delete();
    exp_result = 32'h0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: expected done/busy/result each cycle, popping the scoreboard on completion
  initial begin
    bit exp_done;
    bit exp_busy;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_done = (sb_q.size() > 0) && (sb_q[0].done_cyc == cyc);
        exp_busy = (sb_q.size() > 0) && (cyc >= sb_q[0].done_cyc - LAT) &&
                   (cyc < sb_q[0].done_cyc);
        if (exp_done) begin
          exp_result = sb_q[0].res;
          void'(sb_q.pop_front());
        end
        chk("o_done", {31'h0, o_done}, {31'h0, exp_done});
        chk("o_load_regfile", {31'h0, o_load_regfile}, {31'h0, exp_done});
        chk("o_busy", {31'h0, o_busy}, {31'h0, exp_busy});
        chk("o_result", o_result, exp_result);
      end
    end
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_op    = 3'h0;
    i_A     = 32'h0;
    i_B     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    mon_en  = 1'b1;
    idle(2);

    for (int i = 0; i < 12; i++) begin
      try_issue(d_op[i], d_a[i], d_b[i], d_exp[i]);
      wait_idle(60);
      idle(1);
    end

    // Starts while busy must not disturb the in-flight MUL
    try_issue(OP_MUL, 32'd3, 32'd4, 32'd12);
    idle(4);
    try_issue(OP_DIV, 32'd1000, 32'd3, ref_model(OP_DIV, 32'd1000, 32'd3));
    idle(14);
    try_issue(OP_DIV, 32'd77, 32'd0, ref_model(OP_DIV, 32'd77, 32'd0));
    wait_idle(60);
    idle(3);

    // Back-to-back issue in the done cycle
    try_issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
    for (int k = 0; k < 100 && cyc < last_done; k++) idle(1);
    try_issue(OP_MUL, 32'd2, 32'd3, 32'd6);
    wait_idle(60);
    idle(2);

    // Reset mid-divide, then reset together with a start request
    try_issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    idle(9);
    do_reset(1'b0);
    idle(3);
    do_reset(1'b1);
    idle(2);
    try_issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    wait_idle(60);
    idle(1);

    for (int i = 0; i < 300; i++) begin
      r_op = 3'($urandom);
      r_a  = pick_operand();
      r_b  = pick_operand();
      if ($urandom_range(15) == 0) begin
        r_a = 32'h80000000;
        r_b = 32'hFFFFFFFF;
      end
      try_issue(r_op, r_a, r_b, ref_model(r_op, r_a, r_b));
      idle($urandom_range(40));
    end
    wait_idle(60);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multi-cycle sequencer for the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- The CPU control FSM issues these to it instead of the single-cycle ALU path, and stalls on o_busy.
- Uses a shift-add multiplier and a restoring divider sharing one 64-bit accumulator, one bit per cycle.
- Fixed latency; RISC-V-exact results, including the divide-by-zero and overflow cases.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- i_clk  input  1  clock, all logic on the rising edge
- i_reset  input  1  synchronous active-high reset
- i_start  input  1  issue request; accepted only when o_busy=0
- i_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_A  input  XLEN  rs1 operand (multiplicand/dividend)
- i_B  input  XLEN  rs2 operand (multiplier/divisor)
- o_busy  output  1  operation in flight; further starts ignored
- o_done  output  1  one-cycle pulse: o_result valid
- o_result  output  XLEN  result, held until the next completion or reset
- o_load_regfile  output  1  equals o_done; regfile write strobe

Behaviour:
- Reset (i_reset=1 at an edge, including mid-operation):
  - State returns to IDLE; o_busy=0, o_done=0, o_result=0, o_load_regfile=0 after that edge.
  - The in-flight operation is discarded; no done pulse follows.
- States: IDLE, CALC, FIX.
- IDLE:
  - At edge E with i_start=1, i_op/i_A/i_B are sampled (only then); the inputs may change freely afterwards.
  - Also latched at E: the signs, the magnitudes |A| and |B| per op signedness, the special-case flags, and iteration counter = 0.
  - Next state is CALC; o_busy=1 from E.
- Operand signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- CALC: one iteration per edge, XLEN edges (E+1..E+XLEN); counter increments, leaving after count XLEN-1.
  - Multiply: unsigned shift-add of the magnitudes into the 64-bit product.
  - Divide: restoring step; the remainder uses the upper half and the quotient shifts into the lower half.
- FIX: one edge (E+XLEN+1).
  - Apply sign: negate the product if the signs differ; negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select output: MUL gives the low XLEN bits; MULH, MULHSU and MULHU give the high XLEN bits; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register o_result, set o_done=o_load_regfile=1, o_busy=0, and go to IDLE.
- Latency: o_done is high during the cycle after edge E+XLEN+1 (E+33 for XLEN=32), fixed for all ops and operands.
- Done cycle:
  - The block is in IDLE, so an i_start in the same cycle is accepted at the next edge (back-to-back issue).
  - o_done drops after one cycle unless it is re-asserted by a completion.
- Special cases (detected at accept, still full latency, overridden in FIX):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend unchanged.
  - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- i_start while o_busy=1: ignored, with no effect on the in-flight operation; the requester must hold or retry.
- i_start and i_reset in the same cycle: reset wins, nothing is accepted.
- All arithmetic is modulo 2^XLEN (low half) or 2^(2·XLEN) (product); there are no exceptions or traps.

Test Plan:
- MUL 7 × 0xFFFFFFFD → o_result=0xFFFFFFEB; MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - Each case: o_done pulses exactly 33 cycles after the start edge, o_busy is high for the intervening cycles, and o_load_regfile equals o_done.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0; each at full 33-cycle latency.
- Start MUL 3×4, pulse i_start with DIV operands at cycles +5 and +20 → single completion with result 12; o_result is unchanged until the next accepted op.
- Back-to-back: assert i_start with MUL 2×3 in the done cycle of a prior op.
  - The new op is accepted; result 6 appears 33 cycles later.
  - The prior result is held in the interim.
- Assert i_reset at cycle +10 of a DIV → o_busy=0, o_result=0 next cycle; no o_done pulse; a fresh op afterwards completes correctly.
